weight_channel_scheduler: RTL and testbench

WEIGHT_CHANNEL_SCHEDULER -- requirements
Module: weight_channel_scheduler

---
 rtl/weight_channel_scheduler.sv | 122 ++++++++++++
 tb/tb_weight_channel_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_channel_scheduler.sv
// Weight channel scheduler: steps a weight buffer through CHANNEL_NUM input
// channels per layer. Each channel is loaded (with a timeout), then held ready
// until the convolution engine finishes it. A Moore FSM with registered outputs.
module weight_channel_scheduler #(
  parameter int CHANNEL_NUM       = 16,
  parameter int CHANNEL_DATAWIDTH = 5,
  parameter int TIMEOUT_CYCLES    = 15,
  parameter int COUNTER_DATAWIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         weight_OK,
  input  logic                         conv_done,
  output logic                         enable,
  output logic                         change,
  output logic                         weights_valid,
  output logic [CHANNEL_DATAWIDTH-1:0] channel_index,
  output logic                         busy,
  output logic                         layer_done,
  output logic                         timeout_err
);

  localparam logic [CHANNEL_DATAWIDTH-1:0] LAST_CH =
    CHANNEL_DATAWIDTH'(CHANNEL_NUM - 1);
  localparam logic [COUNTER_DATAWIDTH-1:0] LAST_WAIT =
    COUNTER_DATAWIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_CHANGE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                         state, state_n;
  logic [COUNTER_DATAWIDTH-1:0]   wait_cnt, wait_cnt_n;
  logic [CHANNEL_DATAWIDTH-1:0]   index_n;

  // Next-state, timeout counter and channel index sequencing.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    index_n    = channel_index;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_LOAD;
          wait_cnt_n = '0;
          index_n    = '0;
        end
      end
      S_LOAD: begin
        // weight_OK takes priority over an expiring timeout in the same cycle
        if (weight_OK) begin
          state_n    = S_READY;
          wait_cnt_n = '0;
        end else if (wait_cnt == LAST_WAIT) begin
          state_n    = S_ERROR;
          wait_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      S_READY: begin
        if (conv_done) begin
          state_n = (channel_index == LAST_CH) ? S_DONE : S_CHANGE;
        end
      end
      S_CHANGE: begin
        state_n    = S_LOAD;
        wait_cnt_n = '0;
        index_n    = channel_index + 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
        index_n = '0;
      end
      S_ERROR: begin
        if (start) begin
          state_n    = S_LOAD;
          wait_cnt_n = '0;
          index_n    = '0;
        end
      end
      default: begin
        state_n    = S_IDLE;
        wait_cnt_n = '0;
        index_n    = '0;
      end
    endcase
  end

  // State, counter and outputs; outputs are registered from the next state so
  // they always match the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      channel_index <= '0;
      enable        <= 1'b0;
      change        <= 1'b0;
      weights_valid <= 1'b0;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      wait_cnt      <= wait_cnt_n;
      channel_index <= index_n;
      enable        <= (state_n == S_LOAD) || (state_n == S_READY);
      change        <= (state_n == S_CHANGE);
      weights_valid <= (state_n == S_READY);
      busy          <= (state_n != S_IDLE) && (state_n != S_ERROR);
      layer_done    <= (state_n == S_DONE);
      timeout_err   <= (state_n == S_ERROR);
    end
  end

endmodule

// File: tb/tb_weight_channel_scheduler.sv
// Testbench for weight_channel_scheduler: a 3-channel instance exercised with
// scripted and randomized layers, plus a 1-channel instance.
module tb_weight_channel_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, weight_OK, conv_done;
  logic       enable, change, weights_valid, busy, layer_done, timeout_err;
  logic [4:0] channel_index;
  logic       start1, weight_OK1, conv_done1;
  logic       enable1, change1, weights_valid1, busy1, layer_done1, timeout_err1;
  logic [4:0] channel_index1;

  int checks = 0;
  int errors = 0;
  int n_change = 0, n_done = 0, n_change1 = 0, n_done1 = 0;

  // Output flag vectors {enable, change, weights_valid, busy, layer_done, timeout_err}
  localparam logic [5:0] F_IDLE   = 6'b000000;
  localparam logic [5:0] F_LOAD   = 6'b100100;
  localparam logic [5:0] F_READY  = 6'b101100;
  localparam logic [5:0] F_CHANGE = 6'b010100;
  localparam logic [5:0] F_DONE   = 6'b000110;
  localparam logic [5:0] F_ERR    = 6'b000001;

  weight_channel_scheduler #(
    .CHANNEL_NUM(3), .CHANNEL_DATAWIDTH(5), .TIMEOUT_CYCLES(15), .COUNTER_DATAWIDTH(4)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .weight_OK(weight_OK),
    .conv_done(conv_done), .enable(enable), .change(change),
    .weights_valid(weights_valid), .channel_index(channel_index), .busy(busy),
    .layer_done(layer_done), .timeout_err(timeout_err)
  );

  weight_channel_scheduler #(
    .CHANNEL_NUM(1), .CHANNEL_DATAWIDTH(5), .TIMEOUT_CYCLES(15), .COUNTER_DATAWIDTH(4)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .weight_OK(weight_OK1),
    .conv_done(conv_done1), .enable(enable1), .change(change1),
    .weights_valid(weights_valid1), .channel_index(channel_index1), .busy(busy1),
    .layer_done(layer_done1), .timeout_err(timeout_err1)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs0();
    return {enable, change, weights_valid, busy, layer_done, timeout_err, channel_index};
  endfunction

  function automatic logic [10:0] obs1();
    return {enable1, change1, weights_valid1, busy1, layer_done1, timeout_err1, channel_index1};
  endfunction

  // Pulse counters and index range monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (change)      n_change++;
    if (layer_done)  n_done++;
    if (change1)     n_change1++;
    if (layer_done1) n_done1++;
    checks++;
    if (channel_index > 5'd2) begin
      errors++;
      $display("FAIL index_range: got %0d want <= 2", channel_index);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One layer on the 3-channel DUT. fix_w/fix_c < 0 selects random delays;
  // fail_ch >= 0 withholds weight_OK on that channel until the timeout fires.
  task automatic run_layer(input string tag, input int fail_ch, input int fix_w, input int fix_c);
    int base_chg = n_change;
    int base_done = n_done;
    logic [10:0] exp;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      int dw = (fix_w >= 0) ? fix_w : int'($urandom_range(0, 14));
      int dc = (fix_c >= 0) ? fix_c : int'($urandom_range(0, 6));
      exp = {F_LOAD, 5'(c)};
      checks++;
      if (obs0() !== exp) begin errors++; $display("FAIL %s load_entry ch%0d: got %b want %b", tag, c, obs0(), exp); end
      if (c == fail_ch) begin
        for (int k = 0; k < 14; k++) begin
          conv_done = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
          step();
        end
        conv_done = 1'b0; start = 1'b0;
        checks++;
        if (obs0() !== exp) begin errors++; $display("FAIL %s load_cycle15 ch%0d: got %b want %b", tag, c, obs0(), exp); end
        step();
        exp = {F_ERR, 5'(c)};
        checks++;
        if (obs0() !== exp) begin errors++; $display("FAIL %s timeout ch%0d: got %b want %b", tag, c, obs0(), exp); end
        checks++;
        if ((n_change - base_chg) !== c || (n_done - base_done) !== 0) begin
          errors++; $display("FAIL %s timeout_pulses: got chg %0d done %0d want %0d 0", tag, n_change - base_chg, n_done - base_done, c);
        end
        return;
      end
      for (int k = 0; k < dw; k++) begin
        weight_OK = 1'b0; conv_done = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
        step();
        checks++;
        if (obs0() !== exp) begin errors++; $display("FAIL %s load_hold ch%0d: got %b want %b", tag, c, obs0(), exp); end
      end
      weight_OK = 1'b1; conv_done = 1'b0; start = 1'b0;
      step();
      weight_OK = 1'b0;
      exp = {F_READY, 5'(c)};
      checks++;
      if (obs0() !== exp) begin errors++; $display("FAIL %s ready ch%0d dw%0d: got %b want %b", tag, c, dw, obs0(), exp); end
      for (int k = 0; k < dc; k++) begin
        start = 1'($urandom_range(0, 1)); weight_OK = 1'($urandom_range(0, 1));
        step();
        checks++;
        if (obs0() !== exp) begin errors++; $display("FAIL %s ready_hold ch%0d: got %b want %b", tag, c, obs0(), exp); end
      end
      start = 1'b0; weight_OK = 1'b0; conv_done = 1'b1;
      step();
      conv_done = 1'b0;
      if (c < 2) begin
        exp = {F_CHANGE, 5'(c)};
        checks++;
        if (obs0() !== exp) begin errors++; $display("FAIL %s change ch%0d: got %b want %b", tag, c, obs0(), exp); end
        step();
      end else begin
        exp = {F_DONE, 5'd2};
        checks++;
        if (obs0() !== exp) begin errors++; $display("FAIL %s layer_done: got %b want %b", tag, obs0(), exp); end
        step();
        exp = {F_IDLE, 5'd0};
        checks++;
        if (obs0() !== exp) begin errors++; $display("FAIL %s idle_after: got %b want %b", tag, obs0(), exp); end
      end
    end
    checks++;
    if ((n_change - base_chg) !== 2 || (n_done - base_done) !== 1) begin
      errors++; $display("FAIL %s pulse_counts: got chg %0d done %0d want 2 1", tag, n_change - base_chg, n_done - base_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; weight_OK = 0; conv_done = 0;
    start1 = 0; weight_OK1 = 0; conv_done1 = 0;
    #12;
    checks++;
    if (obs0() !== {F_IDLE, 5'd0}) begin errors++; $display("FAIL reset_dut: got %b want %b", obs0(), {F_IDLE, 5'd0}); end
    checks++;
    if (obs1() !== {F_IDLE, 5'd0}) begin errors++; $display("FAIL reset_dut1: got %b want %b", obs1(), {F_IDLE, 5'd0}); end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs0() !== {F_IDLE, 5'd0}) begin errors++; $display("FAIL reset_release_idle: got %b want %b", obs0(), {F_IDLE, 5'd0}); end
    end
  endtask

  task automatic test_nominal();
    run_layer("nominal", -1, 3, 5);
  endtask

  task automatic test_late_weight_ok();
    run_layer("late_wok", -1, 14, 1);
  endtask

  task automatic test_timeout();
    run_layer("timeout", 1, 2, 2);
    weight_OK = 1'b1; conv_done = 1'b1;
    step();
    weight_OK = 1'b0; conv_done = 1'b0;
    checks++;
    if (obs0() !== {F_ERR, 5'd1}) begin errors++; $display("FAIL error_sticky: got %b want %b", obs0(), {F_ERR, 5'd1}); end
    run_layer("restart", -1, -1, -1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; step(); start = 1'b0;
    weight_OK = 1'b1; step(); weight_OK = 1'b0;
    conv_done = 1'b1; step(); conv_done = 1'b0;
    step();
    weight_OK = 1'b1; step(); weight_OK = 1'b0;
    checks++;
    if (obs0() !== {F_READY, 5'd1}) begin errors++; $display("FAIL midreset_setup: got %b want %b", obs0(), {F_READY, 5'd1}); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs0() !== {F_IDLE, 5'd0}) begin errors++; $display("FAIL midreset_async: got %b want %b", obs0(), {F_IDLE, 5'd0}); end
    #3 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      weight_OK = 1'($urandom_range(0, 1)); conv_done = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (obs0() !== {F_IDLE, 5'd0}) begin errors++; $display("FAIL midreset_wait: got %b want %b", obs0(), {F_IDLE, 5'd0}); end
    end
    weight_OK = 1'b0; conv_done = 1'b0;
    run_layer("after_reset", -1, -1, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      int fc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_layer("random", fc, -1, -1);
    end
    run_layer("random_final", -1, -1, -1);
  endtask

  task automatic test_single_channel();
    start1 = 1'b1; step(); start1 = 1'b0;
    checks++;
    if (obs1() !== {F_LOAD, 5'd0}) begin errors++; $display("FAIL single_load: got %b want %b", obs1(), {F_LOAD, 5'd0}); end
    step(); step();
    weight_OK1 = 1'b1; step(); weight_OK1 = 1'b0;
    checks++;
    if (obs1() !== {F_READY, 5'd0}) begin errors++; $display("FAIL single_ready: got %b want %b", obs1(), {F_READY, 5'd0}); end
    step(); step(); step();
    conv_done1 = 1'b1; step(); conv_done1 = 1'b0;
    checks++;
    if (obs1() !== {F_DONE, 5'd0}) begin errors++; $display("FAIL single_done: got %b want %b", obs1(), {F_DONE, 5'd0}); end
    step();
    checks++;
    if (obs1() !== {F_IDLE, 5'd0}) begin errors++; $display("FAIL single_idle: got %b want %b", obs1(), {F_IDLE, 5'd0}); end
    checks++;
    if (n_change1 !== 0 || n_done1 !== 1) begin
      errors++; $display("FAIL single_pulses: got chg %0d done %0d want 0 1", n_change1, n_done1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_late_weight_ok();
    test_timeout();
    test_reset_mid();
    test_random();
    test_single_channel();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
